branch_resolve: RTL

- Execute-stage branch resolution unit, directly downstream of the ALU; consumes the ALU result (f) and zero flag for the instruction currently in EX.
- Computes the actual outcome and target of conditional branches, JAL and JALR, and compares them with the fetch-time prediction.
- Issues a registered one-cycle redirect/flush on mispredict.
- Queues predictor-update records to the BPU through a valid/ready port, and keeps saturating branch and mispredict counters.

---
 rtl/core_pkg.sv | 25 ++
 rtl/bpu_upd_fifo.sv | 63 ++++++
 rtl/branch_resolve.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for execute-stage branch resolution and the BPU update path.
// Holds the branch condition encoding, the update record layout and the instruction size.
package core_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int BR_XLEN     = 32;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_funct3_e;

    typedef struct packed {
        logic [BR_XLEN-1:0] pc;
        logic               taken;
        logic [BR_XLEN-1:0] target;
        logic               mispredict;
        logic               is_jump;
    } bpu_update_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// First-word-fall-through FIFO of BPU update records.
// Latency: a pushed record is visible at the head on the next cycle.
// Backpressure: push is taken when not full, or when full and popping in the same cycle.
module bpu_upd_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_vld,
    input  bpu_update_t push_dat,
    input  logic        pop,
    output bpu_update_t head_dat,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    bpu_update_t mem_q [DEPTH];
    bpu_update_t mem_d [DEPTH];
    logic push_en;
    logic pop_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop_en   = pop & ~empty;
        push_en  = push_vld & (~full | pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves branches/JAL/JALR in EX against the fetch prediction; redirects and queues BPU updates.
// Latency: redirect, misalign and counters update one cycle after acceptance.
// Backpressure: ex_stall holds EX while the update FIFO is full and the BPU is not ready.
module branch_resolve
    import core_pkg::*;
#(
    parameter int XLEN      = BR_XLEN,
    parameter int UPD_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  alu_f,
    input  logic             alu_zero,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             ex_stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             misalign_excp,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [XLEN-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [XLEN-1:0]  upd_target,
    output logic             upd_mispredict,
    output logic             upd_is_jump,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             kill_q, kill_d;
    logic             redirect_q, redirect_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
    logic [CNT_W-1:0] cnt_mp_q, cnt_mp_d;

    logic             ctrl, is_jump, taken, mispred, misalign, accept, push, pop;
    logic             full, empty;
    logic [XLEN-1:0]  target;
    bpu_update_t      push_dat, head_dat;

    always_comb begin
        ctrl    = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr) & ~kill_q;
        is_jump = ex_is_jalr | ex_is_jal;
        taken   = 1'b0;
        target  = ex_pc + XLEN'(INSTR_BYTES);
        if (ex_is_jalr) begin
            taken  = 1'b1;
            target = {alu_f[XLEN-1:1], 1'b0};
        end else if (ex_is_jal) begin
            taken  = 1'b1;
            target = ex_pc + ex_imm;
        end else begin
            case (br_funct3_e'(ex_funct3))
                BR_EQ:         taken = alu_zero;
                BR_NE:         taken = ~alu_zero;
                BR_LT, BR_LTU: taken = alu_f[0];
                BR_GE, BR_GEU: taken = ~alu_f[0];
                default:       taken = 1'b0;
            endcase
            if (taken) begin
                target = ex_pc + ex_imm;
            end
        end
        mispred  = (taken != pred_taken) | (taken & (target != pred_target));
        misalign = taken & target[1];

        ex_stall = ctrl & full & ~upd_ready;
        accept   = ctrl & ~ex_stall;
        push     = accept & ~misalign;
        pop      = ~empty & upd_ready;

        push_dat = '{pc: ex_pc, taken: taken, target: target,
                     mispredict: mispred, is_jump: is_jump};

        redirect_d    = accept & mispred & ~misalign;
        redirect_pc_d = redirect_d ? target : '0;
        misalign_d    = accept & misalign;
        // The instruction behind a redirect is wrong-path for exactly one cycle.
        kill_d        = redirect_d;

        cnt_br_d = cnt_br_q;
        cnt_mp_d = cnt_mp_q;
        if (accept && !(&cnt_br_q)) begin
            cnt_br_d = cnt_br_q + CNT_ONE;
        end
        if (redirect_d && !(&cnt_mp_q)) begin
            cnt_mp_d = cnt_mp_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q        <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            misalign_q    <= 1'b0;
            cnt_br_q      <= '0;
            cnt_mp_q      <= '0;
        end else begin
            kill_q        <= kill_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            misalign_q    <= misalign_d;
            cnt_br_q      <= cnt_br_d;
            cnt_mp_q      <= cnt_mp_d;
        end
    end

    bpu_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty)
    );

    assign redirect_valid = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign misalign_excp  = misalign_q;
    assign cnt_branches   = cnt_br_q;
    assign cnt_mispred    = cnt_mp_q;
    assign upd_valid      = ~empty;
    assign upd_pc         = head_dat.pc;
    assign upd_taken      = head_dat.taken;
    assign upd_target     = head_dat.target;
    assign upd_mispredict = head_dat.mispredict;
    assign upd_is_jump    = head_dat.is_jump;

endmodule
